cache_refill_arbiter: RTL

// Shares the single cache-style refill read port (rd_req/rd_type/rd_addr/rd_rdy/ret_*) of the AXI bridge

---
 rtl/cache_refill_arbiter_pkg.sv | 24 ++
 rtl/cache_refill_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/cache_refill_arbiter_pkg.sv
// Shared encodings for the icache/dcache refill-port arbiter.
package cache_refill_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TYPE_W = 3;
  localparam int unsigned LAST_W = 2;
  localparam int unsigned BEAT_W = 2;

  typedef enum logic [2:0] {
    ARB_IDLE  = 3'b001,
    ARB_GRANT = 3'b010,
    ARB_RESP  = 3'b100
  } arb_state_e;

  localparam logic [TYPE_W-1:0] RD_TYPE_LINE = 3'b100;
  localparam logic [TYPE_W-1:0] RD_TYPE_WORD = 3'b010;

  // Index of the final beat: a line wraps the 2-bit counter to 3, anything else ends on beat 0.
  function automatic logic [BEAT_W-1:0] last_beat_idx(input logic [TYPE_W-1:0] rd_type);
    return (rd_type == RD_TYPE_LINE) ? BEAT_W'(3) : BEAT_W'(0);
  endfunction

endpackage

// File: rtl/cache_refill_arbiter.sv
// Arbitrates the bridge refill read port between icache (own=0) and dcache (own=1),
// holding the grant from request acceptance through the final return beat.
module cache_refill_arbiter
  import cache_refill_arbiter_pkg::*;
#(
  parameter int PRIO_MODE = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ic_rd_req,
  input  logic [TYPE_W-1:0] ic_rd_type,
  input  logic [ADDR_W-1:0] ic_rd_addr,
  output logic              ic_rd_rdy,
  output logic              ic_ret_valid,
  output logic [LAST_W-1:0] ic_ret_last,
  output logic [DATA_W-1:0] ic_ret_data,
  input  logic              dc_rd_req,
  input  logic [TYPE_W-1:0] dc_rd_type,
  input  logic [ADDR_W-1:0] dc_rd_addr,
  output logic              dc_rd_rdy,
  output logic              dc_ret_valid,
  output logic [LAST_W-1:0] dc_ret_last,
  output logic [DATA_W-1:0] dc_ret_data,
  output logic              rd_req,
  output logic [TYPE_W-1:0] rd_type,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_rdy,
  input  logic              ret_valid,
  input  logic [LAST_W-1:0] ret_last,
  input  logic [DATA_W-1:0] ret_data
);

  arb_state_e        state;
  arb_state_e        state_next;
  logic              own;
  logic              last;
  logic              win;
  logic              any_req;
  logic [BEAT_W-1:0] beat_cnt;
  logic [TYPE_W-1:0] req_type;

  assign any_req = ic_rd_req | dc_rd_req;

  // Arbitration winner: a lone requester always wins; a tie goes by mode.
  always_comb begin
    win = dc_rd_req;
    if (ic_rd_req && dc_rd_req) begin
      win = (PRIO_MODE == 0) ? 1'b1 : ~last;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    rd_req       = 1'b0;
    rd_type      = '0;
    rd_addr      = '0;
    ic_rd_rdy    = 1'b0;
    dc_rd_rdy    = 1'b0;
    ic_ret_valid = 1'b0;
    ic_ret_last  = '0;
    ic_ret_data  = '0;
    dc_ret_valid = 1'b0;
    dc_ret_last  = '0;
    dc_ret_data  = '0;
    unique case (state)
      ARB_IDLE: begin
        if (any_req) state_next = ARB_GRANT;
      end
      ARB_GRANT: begin
        // A request dropped here by the owner is a protocol error; the grant is kept anyway.
        rd_req  = own ? dc_rd_req  : ic_rd_req;
        rd_type = own ? dc_rd_type : ic_rd_type;
        rd_addr = own ? dc_rd_addr : ic_rd_addr;
        if (own) dc_rd_rdy = rd_rdy;
        else     ic_rd_rdy = rd_rdy;
        if (rd_req && rd_rdy) state_next = ARB_RESP;
      end
      ARB_RESP: begin
        if (own) begin
          dc_ret_valid = ret_valid;
          dc_ret_last  = ret_last;
          dc_ret_data  = ret_data;
        end else begin
          ic_ret_valid = ret_valid;
          ic_ret_last  = ret_last;
          ic_ret_data  = ret_data;
        end
        if (ret_valid && ret_last[0]) state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // Owner, round-robin pointer and beat bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      own      <= 1'b0;
      last     <= 1'b1;
      beat_cnt <= '0;
      req_type <= '0;
    end else begin
      if (state == ARB_IDLE && any_req) own <= win;
      if (state == ARB_GRANT) begin
        beat_cnt <= '0;
        req_type <= rd_type;
      end
      if (state == ARB_RESP && ret_valid) begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
        if (ret_last[0]) last <= own;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (resetn && state == ARB_RESP && ret_valid && ret_last[0] &&
        beat_cnt != last_beat_idx(req_type)) begin
      $error("cache_refill_arbiter: burst ended on beat %0d, type %b", beat_cnt, req_type);
    end
  end
`endif

endmodule
